// File: rtl/conv1_ofmap_buffer_pkg.sv
// Shared constants and types for the conv1 output feature-map buffer.
package conv1_ofmap_buffer_pkg;

  localparam int unsigned BW       = 16;
  localparam int unsigned O_SIZE   = 12;
  localparam int unsigned CO       = 4;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned CH_WORDS = O_SIZE * O_SIZE;
  localparam int unsigned FRAME    = CO * CH_WORDS;
  localparam int unsigned OFF_W    = $clog2(CH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // One slot of the output skid buffer: word plus its stream tags.
  typedef struct packed {
    logic [BW-1:0] data;
    logic          ch_end;
    logic          all_end;
  } skid_entry_t;

endpackage

// File: rtl/sp_bram.sv
// Single-port block RAM with synchronous write and registered read.
module sp_bram #(
  parameter int unsigned mem_data_width    = 16,
  parameter int unsigned mem_address_width = 10,
  parameter int unsigned mem_mem_depth     = 576
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [mem_address_width-1:0] addr,
  input  logic [mem_data_width-1:0]    wr_data,
  output logic [mem_data_width-1:0]    rd_data
);

  logic [mem_data_width-1:0] mem [mem_mem_depth];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
    rd_data <= mem[addr];
  end

endmodule

// File: rtl/conv1_ofmap_buffer.sv
// Captures one conv1 pooled frame into BRAM, then replays it channel-major
// to conv2 through a 2-entry skid buffer on a valid/ready stream.
module conv1_ofmap_buffer
  import conv1_ofmap_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 global_rst_n,
  input  logic                 rst_processEnd,
  input  logic signed [BW-1:0] i_data,
  input  logic                 i_valid,
  input  logic                 i_ch_end,
  output logic signed [BW-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_ch_end,
  output logic                 o_all_end,
  output logic                 o_busy,
  output logic                 o_overflow
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ch_base_q, ch_base_d;
  logic [OFF_W-1:0]    wr_off_q, wr_off_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [OFF_W-1:0]    rd_off_q, rd_off_d;
  logic                rd_done_q, rd_done_d;
  logic                pend_q, pend_d;
  logic                pend_ch_end_q, pend_ch_end_d;
  logic                pend_all_end_q, pend_all_end_d;
  skid_entry_t         sk0_q, sk0_d, sk1_q, sk1_d;
  logic                v0_q, v0_d, v1_q, v1_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [ADDR_W-1:0]   wr_addr;
  logic [BW-1:0]       mem_rdata;
  logic                pop;
  logic [1:0]          occ_after;
  skid_entry_t         rd_entry;

  sp_bram #(
    .mem_data_width    (BW),
    .mem_address_width (ADDR_W),
    .mem_mem_depth     (FRAME)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .addr    (mem_addr),
    .wr_data (i_data),
    .rd_data (mem_rdata)
  );

  always_comb begin
    state_d        = state_q;
    ch_base_d      = ch_base_q;
    wr_off_d       = wr_off_q;
    rd_addr_d      = rd_addr_q;
    rd_off_d       = rd_off_q;
    rd_done_d      = rd_done_q;
    pend_d         = 1'b0;
    pend_ch_end_d  = 1'b0;
    pend_all_end_d = 1'b0;
    sk0_d          = sk0_q;
    sk1_d          = sk1_q;
    v0_d           = v0_q;
    v1_d           = v1_q;
    ovf_d          = ovf_q;
    mem_we         = 1'b0;
    wr_addr        = ch_base_q + ADDR_W'(wr_off_q);
    mem_addr       = wr_addr;
    pop            = v0_q & i_ready;
    // Occupancy once this cycle's pop and the in-flight read have settled.
    occ_after      = 2'(v0_q) + 2'(v1_q) - 2'(pop) + 2'(pend_q);
    rd_entry       = '{data: mem_rdata, ch_end: pend_ch_end_q, all_end: pend_all_end_q};

    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (i_valid) begin
          mem_we  = 1'b1;
          state_d = ST_FILL;
          if (wr_addr == ADDR_W'(FRAME - 1)) begin
            state_d   = ST_DRAIN;
            ch_base_d = '0;
            wr_off_d  = '0;
          end else if (i_ch_end || wr_off_q == OFF_W'(CH_WORDS - 1)) begin
            ch_base_d = ch_base_q + ADDR_W'(CH_WORDS);
            wr_off_d  = '0;
          end else begin
            wr_off_d = wr_off_q + OFF_W'(1);
          end
        end else if (i_ch_end && wr_off_q != '0) begin
          // Short channel: skip to the next channel base, gap is don't-care.
          ch_base_d = ch_base_q + ADDR_W'(CH_WORDS);
          wr_off_d  = '0;
        end
      end
      ST_DRAIN: begin
        mem_addr = rd_addr_q;
        if (i_valid) ovf_d = 1'b1;
        if (!rd_done_q && occ_after < 2'd2) begin
          pend_d         = 1'b1;
          pend_ch_end_d  = (rd_off_q == OFF_W'(CH_WORDS - 1));
          pend_all_end_d = (rd_addr_q == ADDR_W'(FRAME - 1));
          if (rd_addr_q == ADDR_W'(FRAME - 1)) rd_done_d = 1'b1;
          else                                 rd_addr_d = rd_addr_q + ADDR_W'(1);
          rd_off_d = (rd_off_q == OFF_W'(CH_WORDS - 1)) ? '0 : rd_off_q + OFF_W'(1);
        end
        if (pop && sk0_q.all_end) begin
          state_d   = ST_IDLE;
          rd_addr_d = '0;
          rd_off_d  = '0;
          rd_done_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Skid buffer: shift on pop, then land the word returning from BRAM.
    if (pop) begin
      sk0_d = sk1_q;
      v0_d  = v1_q;
      v1_d  = 1'b0;
    end
    if (pend_q) begin
      if (!v0_d) begin
        sk0_d = rd_entry;
        v0_d  = 1'b1;
      end else begin
        sk1_d = rd_entry;
        v1_d  = 1'b1;
      end
    end

    busy_d = (state_d != ST_IDLE);

    if (rst_processEnd) begin
      state_d        = ST_IDLE;
      ch_base_d      = '0;
      wr_off_d       = '0;
      rd_addr_d      = '0;
      rd_off_d       = '0;
      rd_done_d      = 1'b0;
      pend_d         = 1'b0;
      pend_ch_end_d  = 1'b0;
      pend_all_end_d = 1'b0;
      sk0_d          = '0;
      sk1_d          = '0;
      v0_d           = 1'b0;
      v1_d           = 1'b0;
      busy_d         = 1'b0;
      ovf_d          = 1'b0;
      mem_we         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q        <= ST_IDLE;
      ch_base_q      <= '0;
      wr_off_q       <= '0;
      rd_addr_q      <= '0;
      rd_off_q       <= '0;
      rd_done_q      <= 1'b0;
      pend_q         <= 1'b0;
      pend_ch_end_q  <= 1'b0;
      pend_all_end_q <= 1'b0;
      sk0_q          <= '0;
      sk1_q          <= '0;
      v0_q           <= 1'b0;
      v1_q           <= 1'b0;
      busy_q         <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      ch_base_q      <= ch_base_d;
      wr_off_q       <= wr_off_d;
      rd_addr_q      <= rd_addr_d;
      rd_off_q       <= rd_off_d;
      rd_done_q      <= rd_done_d;
      pend_q         <= pend_d;
      pend_ch_end_q  <= pend_ch_end_d;
      pend_all_end_q <= pend_all_end_d;
      sk0_q          <= sk0_d;
      sk1_q          <= sk1_d;
      v0_q           <= v0_d;
      v1_q           <= v1_d;
      busy_q         <= busy_d;
      ovf_q          <= ovf_d;
    end
  end

  assign o_data     = sk0_q.data;
  assign o_valid    = v0_q;
  assign o_ch_end   = sk0_q.ch_end;
  assign o_all_end  = sk0_q.all_end;
  assign o_busy     = busy_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_conv1_ofmap_buffer.sv
// Scoreboard bench for conv1_ofmap_buffer: frame-level reference model feeds an
// expected-word queue, an independent monitor checks every accepted word.
module tb_conv1_ofmap_buffer;
  import conv1_ofmap_buffer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          global_rst_n, rst_processEnd;
  logic [BW-1:0] i_data, o_data;
  logic          i_valid, i_ch_end, i_ready;
  logic          o_valid, o_ch_end, o_all_end, o_busy, o_overflow;

  conv1_ofmap_buffer dut (
    .clk            (clk),
    .global_rst_n   (global_rst_n),
    .rst_processEnd (rst_processEnd),
    .i_data         (i_data),
    .i_valid        (i_valid),
    .i_ch_end       (i_ch_end),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_ch_end       (o_ch_end),
    .o_all_end      (o_all_end),
    .o_busy         (o_busy),
    .o_overflow     (o_overflow)
  );

  typedef struct {
    logic [BW-1:0] data;
    bit            known;
    bit            ch_end;
    bit            all_end;
  } exp_t;

  exp_t          exp_q[$];
  logic [BW-1:0] ref_mem   [FRAME];
  bit            ref_known [FRAME];
  int            model_addr;
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            ready_mode = 0;
  int            hs_first, hs_last, mon_k;
  int            last_wr_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a frame is an array indexed by address, filled per the
  // write/snap rules and released to the scoreboard once address FRAME-1 is written.
  function automatic void model_clear();
    exp_q.delete();
    model_addr = 0;
    for (int k = 0; k < int'(FRAME); k++) ref_known[k] = 1'b0;
  endfunction

  function automatic void model_snap();
    if (model_addr % int'(CH_WORDS) != 0)
      model_addr = (model_addr / int'(CH_WORDS) + 1) * int'(CH_WORDS);
  endfunction

  function automatic void model_word(input logic [BW-1:0] d, input bit ce);
    ref_mem[model_addr]   = d;
    ref_known[model_addr] = 1'b1;
    if (model_addr == int'(FRAME) - 1) begin
      for (int k = 0; k < int'(FRAME); k++) begin
        exp_q.push_back('{ref_mem[k], ref_known[k],
                          (k % int'(CH_WORDS)) == int'(CH_WORDS) - 1,
                          k == int'(FRAME) - 1});
        ref_known[k] = 1'b0;
      end
      model_addr = 0;
    end else begin
      model_addr++;
      if (ce) model_snap();
    end
  endfunction

  task automatic drive(input bit v, input logic [BW-1:0] d, input bit ce, input bit upd);
    i_valid  = v;
    i_data   = d;
    i_ch_end = ce;
    @(posedge clk); #1;
    i_valid  = 1'b0;
    i_ch_end = 1'b0;
    if (upd) begin
      if (v)       model_word(d, ce);
      else if (ce) model_snap();
    end
  endtask

  task automatic send_frame(input bit gaps, input bit short0, input bit short2, input bit rnd);
    int n;
    logic [BW-1:0] d;
    bit ce;
    for (int c = 0; c < int'(CO); c++) begin
      n = int'(CH_WORDS);
      if (c == 0 && short0) n = 140;
      if (c == 2 && short2) n = 100;
      for (int i = 0; i < n; i++) begin
        if (gaps) begin
          drive(1'b0, '0, 1'b0, 1'b1);
          drive(1'b0, '0, 1'b0, 1'b1);
        end
        d  = rnd ? BW'($urandom) : BW'(c * int'(CH_WORDS) + i);
        ce = (i == n - 1) && !(c == 0 && short0);
        drive(1'b1, d, ce, 1'b1);
        if (c == 0 && i == 0) check("busy_after_first_write", 32'(o_busy), 32'd1);
      end
      if (c == 0 && short0) drive(1'b0, '0, 1'b1, 1'b1);
    end
    last_wr_cyc = cyc;
  endtask

  task automatic wait_drained();
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk); #1;
      n++;
    end
    check("drain_remaining_words", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    check("busy_after_drain", 32'(o_busy), 32'd0);
    check("valid_after_drain", 32'(o_valid), 32'd0);
  endtask

  task automatic run_frame(input bit gaps, input bit short0, input bit short2, input bit rnd);
    bit found = 1'b0;
    int lat = 999;
    check("busy_before_frame", 32'(o_busy), 32'd0);
    send_frame(gaps, short0, short2, rnd);
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (o_valid) begin
        found = 1'b1;
        lat   = cyc - last_wr_cyc;
      end
    end
    check("first_valid_latency", 32'(lat), 32'd2);
    wait_drained();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_o_data"},     32'(o_data),     32'd0);
    check({tag, "_o_valid"},    32'(o_valid),    32'd0);
    check({tag, "_o_ch_end"},   32'(o_ch_end),   32'd0);
    check({tag, "_o_all_end"},  32'(o_all_end),  32'd0);
    check({tag, "_o_busy"},     32'(o_busy),     32'd0);
    check({tag, "_o_overflow"}, 32'(o_overflow), 32'd0);
  endtask

  // Consumer: i_ready either held high or random 50%.
  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      i_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares each accepted word and checks stability while stalled.
  bit            stall_prev = 1'b0;
  logic [BW-1:0] prev_data;
  exp_t          e;
  always @(negedge clk) begin
    if (!global_rst_n || rst_processEnd) begin
      stall_prev = 1'b0;
      mon_k      = 0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", 32'(o_valid), 32'd1);
        check("stall_data_held", 32'(o_data), 32'(prev_data));
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: got data %0d, expected no word", o_data);
        end else begin
          e = exp_q.pop_front();
          if (e.known) check($sformatf("data[%0d]", mon_k), 32'(o_data), 32'(e.data));
          check($sformatf("ch_end[%0d]", mon_k), 32'(o_ch_end), 32'(e.ch_end));
          check($sformatf("all_end[%0d]", mon_k), 32'(o_all_end), 32'(e.all_end));
          if (mon_k == 0) hs_first = cyc;
          mon_k++;
          if (e.all_end) begin
            hs_last = cyc;
            mon_k   = 0;
          end
        end
      end
      stall_prev = o_valid && !i_ready;
      prev_data  = o_data;
    end
  end

  initial begin
    global_rst_n   = 1'b0;
    rst_processEnd = 1'b0;
    i_valid        = 1'b0;
    i_ch_end       = 1'b0;
    i_data         = '0;
    mon_k          = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("in_reset");
    global_rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("after_reset");

    // Counting frame, continuous input, always ready.
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("throughput_span", 32'(hs_last - hs_first), 32'(FRAME - 1));

    // Layer-1-like gaps (valid 1 in 3).
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);
    check("gap_throughput_span", 32'(hs_last - hs_first), 32'(FRAME - 1));

    // Random data, random backpressure.
    ready_mode = 1;
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);

    // Short channels: separate ch_end after 140 words, simultaneous ch_end after 100.
    run_frame(1'b0, 1'b1, 1'b1, 1'b1);

    // Writes during DRAIN are dropped and flag overflow.
    ready_mode = 0;
    send_frame(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, BW'($urandom), 1'b0, 1'b0);
    check("overflow_set", 32'(o_overflow), 32'd1);
    wait_drained();
    check("overflow_sticky", 32'(o_overflow), 32'd1);

    // Synchronous clear in the middle of DRAIN.
    ready_mode = 1;
    send_frame(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (50) begin @(posedge clk); #1; end
    check("busy_mid_drain", 32'(o_busy), 32'd1);
    rst_processEnd = 1'b1;
    @(posedge clk); #1;
    rst_processEnd = 1'b0;
    model_clear();
    check_reset_vals("after_rst_processEnd");
    repeat (5) begin @(posedge clk); #1; end
    check("idle_after_rst_processEnd", 32'(o_valid), 32'd0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of FILL.
    for (int i = 0; i < 200; i++) drive(1'b1, BW'($urandom), 1'b0, 1'b1);
    check("busy_mid_fill", 32'(o_busy), 32'd1);
    global_rst_n = 1'b0;
    #2;
    check_reset_vals("async_reset_mid_fill");
    model_clear();
    @(posedge clk); #1;
    global_rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
